// File: rtl/ctxt_writer.sv
// Byte-stream writer for the colour text-mode screen RAM: cursor, attribute, clears.
// Optional cursor-load port is enabled by defining CTXT_WRITER_CURPOS_EN.
module ctxt_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  attr_in,
  input  logic        attr_we,
`ifdef CTXT_WRITER_CURPOS_EN
  input  logic        cur_set,
  input  logic [6:0]  cur_col,
  input  logic [4:0]  cur_row,
`endif
  output logic [15:0] scr_addr,
  output logic [7:0]  scr_wdata,
  output logic        scr_we,
  output logic        busy
);

  // Handshake: a byte transfers on a rising edge where in_valid & in_ready are both 1;
  // in_ready is high only in IDLE, so every accepted byte is decoded from IDLE.

  typedef enum logic [2:0] {IDLE, WR_CHR, WR_ATTR, CLR_SCR, CLR_LINE} state_t;

  localparam logic [6:0] COL_MAX = 7'(COLS - 1);
  localparam logic [4:0] ROW_MAX = 5'(ROWS - 1);

  state_t      state_q, state_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [7:0]  attr_q, attr_d;
  logic [15:0] scr_addr_q, scr_addr_d;
  logic [7:0]  scr_wdata_q, scr_wdata_d;
  logic        scr_we_q, scr_we_d;
  logic        in_ready_q;
  logic        busy_q;

  logic [6:0]  cur_c;
  logic [4:0]  cur_r;
  logic [6:0]  walk_col;
  logic [4:0]  walk_row;
  logic        accept;
  logic        printable;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    attr_d      = attr_we ? attr_in : attr_q;
    scr_we_d    = 1'b0;
    scr_addr_d  = scr_addr_q;
    scr_wdata_d = scr_wdata_q;
    cur_c       = col_q;
    cur_r       = row_q;
`ifdef CTXT_WRITER_CURPOS_EN
    if (state_q == IDLE && cur_set) begin
      cur_c = (cur_col > COL_MAX) ? COL_MAX : cur_col;
      cur_r = (cur_row > ROW_MAX) ? ROW_MAX : cur_row;
    end
`endif
    accept    = in_valid && in_ready_q;
    printable = (in_data >= 8'h20) && (in_data != 8'h7F);
    // During clears the current write address doubles as the walk position.
    walk_col  = scr_addr_q[7:1];
    walk_row  = scr_addr_q[12:8];

    case (state_q)
      IDLE: begin
        col_d = cur_c;
        row_d = cur_r;
        if (accept) begin
          if (printable) begin
            state_d     = WR_CHR;
            scr_we_d    = 1'b1;
            scr_addr_d  = {3'b000, cur_r, cur_c, 1'b1};
            scr_wdata_d = in_data;
          end else begin
            case (in_data)
              8'h0D: col_d = 7'd0;
              8'h0A: begin
                col_d = 7'd0;
                if (cur_r == ROW_MAX) begin
                  row_d       = 5'd0;
                  state_d     = CLR_LINE;
                  scr_we_d    = 1'b1;
                  scr_addr_d  = 16'h0001;
                  scr_wdata_d = 8'h20;
                end else begin
                  row_d = cur_r + 5'd1;
                end
              end
              8'h08: if (cur_c != 7'd0) col_d = cur_c - 7'd1;
              8'h0C: begin
                col_d       = 7'd0;
                row_d       = 5'd0;
                state_d     = CLR_SCR;
                scr_we_d    = 1'b1;
                scr_addr_d  = 16'h0001;
                scr_wdata_d = 8'h20;
              end
              default: ;
            endcase
          end
        end
      end
      WR_CHR: begin
        state_d     = WR_ATTR;
        scr_we_d    = 1'b1;
        scr_addr_d  = {scr_addr_q[15:1], 1'b0};
        scr_wdata_d = attr_d;
      end
      WR_ATTR: begin
        state_d = IDLE;
        if (col_q == COL_MAX) begin
          col_d = 7'd0;
          if (row_q == ROW_MAX) begin
            row_d       = 5'd0;
            state_d     = CLR_LINE;
            scr_we_d    = 1'b1;
            scr_addr_d  = 16'h0001;
            scr_wdata_d = 8'h20;
          end else begin
            row_d = row_q + 5'd1;
          end
        end else begin
          col_d = col_q + 7'd1;
        end
      end
      CLR_SCR, CLR_LINE: begin
        if (scr_addr_q[0]) begin
          scr_we_d    = 1'b1;
          scr_addr_d  = {scr_addr_q[15:1], 1'b0};
          scr_wdata_d = attr_d;
        end else if (walk_col != COL_MAX) begin
          scr_we_d    = 1'b1;
          scr_addr_d  = {3'b000, walk_row, walk_col + 7'd1, 1'b1};
          scr_wdata_d = 8'h20;
        end else if (state_q == CLR_SCR && walk_row != ROW_MAX) begin
          scr_we_d    = 1'b1;
          scr_addr_d  = {3'b000, walk_row + 5'd1, 7'd0, 1'b1};
          scr_wdata_d = 8'h20;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= 7'd0;
      row_q       <= 5'd0;
      attr_q      <= 8'h70;
      scr_addr_q  <= 16'h0000;
      scr_wdata_q <= 8'h00;
      scr_we_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      attr_q      <= attr_d;
      scr_addr_q  <= scr_addr_d;
      scr_wdata_q <= scr_wdata_d;
      scr_we_q    <= scr_we_d;
      in_ready_q  <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign scr_addr  = scr_addr_q;
  assign scr_wdata = scr_wdata_q;
  assign scr_we    = scr_we_q;

endmodule

// File: tb/tb_ctxt_writer.sv
// Scoreboard bench for ctxt_writer: reference model queues expected screen writes
// and in_ready stall lengths; a monitor pops and compares every scr_we strobe.
module tb_ctxt_writer;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int WAIT_LIMIT = 6000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  attr_in = 8'h00;
  logic        attr_we = 1'b0;
  logic [15:0] scr_addr;
  logic [7:0]  scr_wdata;
  logic        scr_we;
  logic        busy;

  int total = 0;
  int bad = 0;

  logic [23:0] exp_q[$];
  int          m_col, m_row;
  logic [7:0]  m_attr;

  ctxt_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .attr_in(attr_in), .attr_we(attr_we),
    .scr_addr(scr_addr), .scr_wdata(scr_wdata), .scr_we(scr_we),
    .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // reference model
  task automatic push_w(input int r, input int c, input bit is_chr, input logic [7:0] d);
    logic [15:0] a;
    a = 16'(r * 256 + c * 2 + (is_chr ? 1 : 0));
    exp_q.push_back({a, d});
  endtask

  task automatic clear_row(input int r);
    for (int c = 0; c < COLS; c++) begin
      push_w(r, c, 1'b1, 8'h20);
      push_w(r, c, 1'b0, m_attr);
    end
  endtask

  task automatic next_row(inout int gap);
    m_row++;
    if (m_row == ROWS) begin
      m_row = 0;
      clear_row(0);
      gap += 2 * COLS;
    end
  endtask

  task automatic model_byte(input logic [7:0] b, output int gap);
    gap = 0;
    if (b >= 8'h20 && b != 8'h7F) begin
      push_w(m_row, m_col, 1'b1, b);
      push_w(m_row, m_col, 1'b0, m_attr);
      gap = 2;
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        next_row(gap);
      end
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h0A) begin
      m_col = 0;
      next_row(gap);
    end else if (b == 8'h08) begin
      if (m_col > 0) m_col--;
    end else if (b == 8'h0C) begin
      for (int r = 0; r < ROWS; r++) clear_row(r);
      m_col = 0;
      m_row = 0;
      gap = 2 * COLS * ROWS;
    end
  endtask

  // driver tasks
  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < WAIT_LIMIT) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic issue_byte(input logic [7:0] b, input bit do_attr, input logic [7:0] a,
                            output int exp_gap);
    wait_ready();
    in_data  = b;
    in_valid = 1'b1;
    attr_we  = do_attr;
    attr_in  = a;
    if (do_attr) m_attr = a;
    model_byte(b, exp_gap);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    attr_we  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit do_attr, input logic [7:0] a);
    int exp_gap;
    int gap;
    issue_byte(b, do_attr, a, exp_gap);
    gap = 0;
    while (!in_ready && gap < WAIT_LIMIT) begin
      @(posedge clk);
      #1;
      gap++;
    end
    chk($sformatf("gap_after_%02h", b), 32'(gap), 32'(exp_gap));
  endtask

  task automatic set_attr(input logic [7:0] a);
    wait_ready();
    attr_we = 1'b1;
    attr_in = a;
    m_attr  = a;
    @(posedge clk);
    #1;
    attr_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_scr_we", {31'd0, scr_we}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_scr_addr", {16'd0, scr_addr}, 32'd0);
    chk("rst_scr_wdata", {24'd0, scr_wdata}, 32'd0);
    m_col  = 0;
    m_row  = 0;
    m_attr = 8'h70;
    rst = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (scr_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr=%h data=%h want none", scr_addr, scr_wdata);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        total++;
        if ({scr_addr, scr_wdata} !== e) begin
          bad++;
          $display("FAIL write: got addr=%h data=%h want addr=%h data=%h",
                   scr_addr, scr_wdata, e[23:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    int g;
    int r;
    logic [7:0] b;

    do_reset();
    wait_ready();
    chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

    // first char, then attr change coinciding with accept
    send_byte(8'h41, 1'b0, 8'h00);
    send_byte(8'h42, 1'b1, 8'h9C);

    // row fill: B lands at row 1 col 0
    send_byte(8'h0D, 1'b0, 8'h00);
    for (int i = 0; i < COLS; i++) send_byte(8'h41, 1'b0, 8'h00);
    send_byte(8'h42, 1'b0, 8'h00);

    // walk to the last row and wrap with LF
    send_byte(8'h0D, 1'b0, 8'h00);
    while (m_row != ROWS - 1) send_byte(8'h0A, 1'b0, 8'h00);
    set_attr(8'h1F);
    send_byte(8'h0A, 1'b0, 8'h00);
    send_byte(8'h5A, 1'b0, 8'h00);

    // full clear, then cursor must be at origin
    set_attr(8'h2E);
    send_byte(8'h0C, 1'b0, 8'h00);
    send_byte(8'h43, 1'b0, 8'h00);

    // backspace / ignored codes
    send_byte(8'h08, 1'b0, 8'h00);
    send_byte(8'h08, 1'b0, 8'h00);
    send_byte(8'h7F, 1'b0, 8'h00);
    send_byte(8'h1B, 1'b0, 8'h00);
    send_byte(8'h44, 1'b0, 8'h00);

    // reset in the middle of a full clear
    issue_byte(8'h0C, 1'b0, 8'h00, g);
    repeat (100) @(posedge clk);
    #1;
    chk("clr_busy", {31'd0, busy}, 32'd1);
    chk("clr_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_scr_we", {31'd0, scr_we}, 32'd0);
    do_reset();
    wait_ready();
    chk("ready_after_abort", {31'd0, in_ready}, 32'd1);
    send_byte(8'h08, 1'b0, 8'h00);
    send_byte(8'h45, 1'b0, 8'h00);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 19);
      if (r < 11) b = 8'($urandom_range(32, 255));
      else if (r < 13) b = 8'h0D;
      else if (r < 15) b = 8'h0A;
      else if (r < 17) b = 8'h08;
      else if (r < 18) b = 8'h7F;
      else b = 8'($urandom_range(0, 31));
      if (b == 8'h0C) b = 8'h0D;
      if ($urandom_range(0, 9) == 0) set_attr(8'($urandom_range(0, 255)));
      send_byte(b, ($urandom_range(0, 7) == 0), 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
